// File: rtl/noc_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : noc_port_arbiter
// Brief   : Round-robin wormhole arbiter for one mesh router output port,
//           with a registered valid/ready output stage.
// Rev     : 1.0
// ============================================================================
module noc_port_arbiter #(
  parameter int NUM_REQ    = 5,
  parameter int FLIT_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*FLIT_WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]            i_req_last,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_out_valid,
  output logic [FLIT_WIDTH-1:0]         o_out_data,
  output logic                          o_out_last,
  input  logic                          i_out_ready,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] C_LAST_IDX = PTR_W'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [PTR_W-1:0]        gnt_idx_q, gnt_idx_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic [FLIT_WIDTH-1:0]   out_data_q, out_data_d;

  logic                    hi_found, lo_found, rr_found;
  logic [PTR_W-1:0]        hi_idx, lo_idx, rr_idx;
  logic [NUM_REQ-1:0]      rr_onehot;

  logic                    sel_valid, sel_last;
  logic [FLIT_WIDTH-1:0]   sel_data;
  logic [FLIT_WIDTH-1:0]   masked_data [NUM_REQ];
  logic                    space, xfer;

  // Round-robin search: lowest requester at or above ptr wins, else lowest below.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req_valid[k]) begin
        if (PTR_W'(k) >= ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = PTR_W'(k);
        end else begin
          lo_found = 1'b1;
          lo_idx   = PTR_W'(k);
        end
      end
    end
    rr_found = hi_found | lo_found;
    rr_idx   = hi_found ? hi_idx : lo_idx;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_onehot[k] = (rr_idx == PTR_W'(k));
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_flit_mask
    assign masked_data[g] = grant_q[g] ? i_req_data[g*FLIT_WIDTH +: FLIT_WIDTH]
                                       : '0;
  end

  always_comb begin
    sel_valid = |(i_req_valid & grant_q);
    sel_last  = |(i_req_last & grant_q);
    sel_data  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_data = sel_data | masked_data[k];
    end
  end

  assign space = ~out_valid_q | i_out_ready;
  assign xfer  = (state_q == ST_LOCKED) & sel_valid & space;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gnt_idx_d   = gnt_idx_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    if (out_valid_q && i_out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          state_d   = ST_LOCKED;
          grant_d   = rr_onehot;
          gnt_idx_d = rr_idx;
        end
      end
      ST_LOCKED: begin
        if (xfer) begin
          out_valid_d = 1'b1;
          out_data_d  = sel_data;
          out_last_d  = sel_last;
          // The lock and the fairness pointer only move on a completed tail.
          if (sel_last) begin
            state_d = ST_IDLE;
            grant_d = '0;
            ptr_d   = (gnt_idx_q == C_LAST_IDX) ? '0 : gnt_idx_q + PTR_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      gnt_idx_q   <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gnt_idx_q   <= gnt_idx_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign o_req_ready = xfer ? grant_q : '0;
  assign o_out_valid = out_valid_q;
  assign o_out_data  = out_data_q;
  assign o_out_last  = out_last_q;
  assign o_grant     = grant_q;
  assign o_busy      = (state_q == ST_LOCKED);

`ifndef SYNTHESIS
  a_grant_onehot0 : assert property (@(posedge clk) disable iff (!reset)
    $onehot0(grant_q));

  a_busy_has_grant : assert property (@(posedge clk) disable iff (!reset)
    (state_q == ST_LOCKED) == (grant_q != '0));

  a_out_stable : assert property (@(posedge clk) disable iff (!reset)
    (out_valid_q && !i_out_ready) |=>
      (out_valid_q && $stable(out_data_q) && $stable(out_last_q)));
`endif

endmodule

`default_nettype wire
